// File: rtl/and_gate_if.sv
// Bundles the AND operands with the immediate, registered and activity outputs.
// The driver of a/b uses master; and_gate uses slave.
interface and_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             y_all;
  logic [WIDTH-1:0] y_q;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] hi_count;

  modport master (
    output a, b,
    input  y, y_all, y_q, rise, fall, hi_count
  );

  modport slave (
    input  a, b,
    output y, y_all, y_q, rise, fall, hi_count
  );
endinterface

// File: rtl/and_gate.sv
// Bitwise AND with a clock-free combinational result plus a registered shadow,
// all-ones edge pulses and a saturating count of cycles spent all-ones.
module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input logic       clk,
  input logic       rst,
  and_gate_if.slave bus
);

  logic [WIDTH-1:0] y_c;
  logic             y_all_c;
  logic             y_all_d;
  logic [WIDTH-1:0] y_q_r;
  logic             rise_r;
  logic             fall_r;
  logic [CNT_W-1:0] hi_count_r;

  // Kept independent of clk/rst so the gate works with the clock stopped.
  assign y_c      = bus.a & bus.b;
  assign y_all_c  = &y_c;
  assign bus.y    = y_c;
  assign bus.y_all = y_all_c;

  assign bus.y_q      = y_q_r;
  assign bus.rise     = rise_r;
  assign bus.fall     = fall_r;
  assign bus.hi_count = hi_count_r;

  // Edges are judged only between consecutive samples, so sub-cycle glitches vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q_r      <= '0;
      y_all_d    <= 1'b0;
      rise_r     <= 1'b0;
      fall_r     <= 1'b0;
      hi_count_r <= '0;
    end else begin
      y_q_r   <= y_c;
      y_all_d <= y_all_c;
      rise_r  <= y_all_c & ~y_all_d;
      fall_r  <= ~y_all_c & y_all_d;
      if (y_all_c && (hi_count_r != {CNT_W{1'b1}}))
        hi_count_r <= hi_count_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: directed tables on WIDTH=1/CNT_W=3 and
// WIDTH=4, then random operands on WIDTH=4 against a sample-history model.
module tb_and_gate;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       yAll;
  } vec_t;

  logic clk;
  logic rst;
  logic clkRun;
  int   passCount;
  int   checkCount;

  and_gate_if #(.WIDTH(1), .CNT_W(3)) bus1 ();
  and_gate_if #(.WIDTH(4), .CNT_W(8)) bus4 ();

  and_gate #(.WIDTH(1), .CNT_W(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  and_gate #(.WIDTH(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 if (clkRun) clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv);
    bus1.a = av[0];
    bus1.b = bv[0];
    bus4.a = av;
    bus4.b = bv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  // Reference: ideal AND per bit, and activity derived from the list of samples.
  function automatic logic [3:0] modelAnd(input logic [3:0] av, input logic [3:0] bv);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (av[i] == 1'b1 && bv[i] == 1'b1);
    return r;
  endfunction

  vec_t tab1[4];
  vec_t tab4[4];
  bit   samples[$];
  logic [3:0] ra, rb, expY, lastY;
  int   ones;
  bit   curS, prevS;

  initial begin
    tab1[0] = '{4'h0, 4'h0, 4'h0, 1'b0};
    tab1[1] = '{4'h0, 4'h1, 4'h0, 1'b0};
    tab1[2] = '{4'h1, 4'h0, 4'h0, 1'b0};
    tab1[3] = '{4'h1, 4'h1, 4'h1, 1'b1};
    tab4[0] = '{4'b1100, 4'b1010, 4'b1000, 1'b0};
    tab4[1] = '{4'hF, 4'hF, 4'hF, 1'b1};
    tab4[2] = '{4'b0111, 4'hF, 4'b0111, 1'b0};
    tab4[3] = '{4'h5, 4'hA, 4'h0, 1'b0};

    passCount = 0;
    checkCount = 0;
    clkRun = 1'b0;
    rst = 1'b0;
    applyStimulus(4'h0, 4'h0);
    #1 rst = 1'b1;
    #1;

    checkOutput("reset y_q", 32'(bus1.y_q), 0);
    checkOutput("reset rise", 32'(bus1.rise), 0);
    checkOutput("reset fall", 32'(bus1.fall), 0);
    checkOutput("reset hi_count", 32'(bus1.hi_count), 0);

    // Clock stopped and reset held: combinational path must still work.
    foreach (tab1[i]) begin
      applyStimulus(tab1[i].a, tab1[i].b);
      #10;
      checkOutput($sformatf("w1 y[%0d]", i), 32'(bus1.y), 32'(tab1[i].y[0]));
      checkOutput($sformatf("w1 y_all[%0d]", i), 32'(bus1.y_all), 32'(tab1[i].yAll));
    end
    foreach (tab4[i]) begin
      applyStimulus(tab4[i].a, tab4[i].b);
      #10;
      checkOutput($sformatf("w4 y[%0d]", i), 32'(bus4.y), 32'(tab4[i].y));
      checkOutput($sformatf("w4 y_all[%0d]", i), 32'(bus4.y_all), 32'(tab4[i].yAll));
    end

    applyStimulus(4'h1, 4'h1);
    clkRun = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("pre-edge y_q", 32'(bus1.y_q), 0);
    tick();
    checkOutput("edge1 y_q", 32'(bus1.y_q), 1);
    checkOutput("edge1 rise", 32'(bus1.rise), 1);
    checkOutput("edge1 fall", 32'(bus1.fall), 0);
    checkOutput("edge1 hi_count", 32'(bus1.hi_count), 1);
    tick();
    checkOutput("edge2 rise", 32'(bus1.rise), 0);
    checkOutput("edge2 hi_count", 32'(bus1.hi_count), 2);
    @(negedge clk);
    applyStimulus(4'h1, 4'h0);
    tick();
    checkOutput("drop fall", 32'(bus1.fall), 1);
    checkOutput("drop rise", 32'(bus1.rise), 0);
    checkOutput("drop y_q", 32'(bus1.y_q), 0);
    checkOutput("drop hi_count", 32'(bus1.hi_count), 2);
    tick();
    checkOutput("after drop fall", 32'(bus1.fall), 0);

    applyStimulus(4'h1, 4'h1);
    resetPulse();
    for (int i = 1; i <= 10; i++) begin
      tick();
      checkOutput($sformatf("sat hi_count[%0d]", i), 32'(bus1.hi_count), (i < 7) ? i : 7);
    end

    resetPulse();
    for (int i = 0; i < 5; i++) tick();
    checkOutput("pre-async hi_count", 32'(bus1.hi_count), 5);
    #2 rst = 1'b1;
    #1;
    checkOutput("async hi_count", 32'(bus1.hi_count), 0);
    checkOutput("async y_q", 32'(bus1.y_q), 0);
    checkOutput("async rise", 32'(bus1.rise), 0);
    checkOutput("async fall", 32'(bus1.fall), 0);
    checkOutput("async y", 32'(bus1.y), 1);
    checkOutput("async y_all", 32'(bus1.y_all), 1);
    @(negedge clk);
    rst = 1'b0;

    tick();
    checkOutput("glitch pre rise", 32'(bus1.rise), 1);
    tick();
    #1 bus1.a = 1'b0;
    #1;
    checkOutput("glitch low y_all", 32'(bus1.y_all), 0);
    #1 bus1.a = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("glitch rise[%0d]", i), 32'(bus1.rise), 0);
      checkOutput($sformatf("glitch fall[%0d]", i), 32'(bus1.fall), 0);
    end
    checkOutput("glitch hi_count", 32'(bus1.hi_count), 4);

    applyStimulus(4'h0, 4'h0);
    resetPulse();
    samples.delete();
    for (int i = 0; i < 600; i++) begin
      if (i > 0) @(negedge clk);
      if ($urandom_range(1, 0) == 1) begin
        ra = 4'hF;
        rb = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'hF;
      end else begin
        ra = 4'($urandom);
        rb = 4'($urandom);
      end
      applyStimulus(ra, rb);
      expY = modelAnd(ra, rb);
      #1;
      checkOutput("rand y", 32'(bus4.y), 32'(expY));
      checkOutput("rand y_all", 32'(bus4.y_all), 32'(expY == 4'hF));
      tick();
      samples.push_back(expY == 4'hF);
      lastY = expY;
      curS  = samples[samples.size()-1];
      prevS = (samples.size() >= 2) ? samples[samples.size()-2] : 1'b0;
      ones = 0;
      foreach (samples[k]) ones += int'(samples[k]);
      checkOutput("rand y_q", 32'(bus4.y_q), 32'(lastY));
      checkOutput("rand rise", 32'(bus4.rise), 32'(curS && !prevS));
      checkOutput("rand fall", 32'(bus4.fall), 32'(!curS && prevS));
      checkOutput("rand hi_count", 32'(bus4.hi_count), (ones > 255) ? 255 : ones);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/and_gate.md
# and_gate

Bitwise two-input AND primitive with a registered shadow and simple activity monitoring. The combinational path `y = a & b` is the primary function and must work with no clock activity. The clocked section is a registered copy, edge pulses on the all-ones condition, and a saturating high-time counter. It sits at leaf level in gate-level datapaths and in glue logic that needs both an immediate and a pipelined AND result.

## Interface
- `WIDTH`, default 1: bit width of `a`, `b`, `y`, `y_q`.
- `CNT_W`, default 8: width of `hi_count`.
- `clk` input 1: single clock, rising-edge active.
- `rst` input 1: asynchronous, active-high reset.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `y` output WIDTH: combinational `a & b`.
- `y_all` output 1: combinational reduction AND of `y`, i.e. all bits of `a & b` are 1.
- `y_q` output WIDTH: `y` registered on `clk`.
- `rise` output 1: one-cycle pulse when `y_all` goes 0→1 between consecutive clock samples.
- `fall` output 1: one-cycle pulse when `y_all` goes 1→0 between consecutive clock samples.
- `hi_count` output CNT_W: count of clock edges where `y_all` was sampled 1. Saturates.

## Operation
- `y` is purely combinational and does not depend on `clk` or `rst`.
  - For each bit i, `y[i] = a[i] & b[i]`.
  - Truth table per bit: 00→0, 01→0, 10→0, 11→1.
- `y_all = &y`. When WIDTH=1, `y_all` equals `y`.
- Internal register `y_all_d` holds `y_all` sampled at the previous clock edge.
- `rise = y_all & ~y_all_d`, registered. `fall = ~y_all & y_all_d`, registered.
- `hi_count` increments by 1 on each clock edge where `y_all` = 1.
  - At all-ones (2^CNT_W − 1) it holds; it never wraps.
  - It only clears on reset.
- X/Z on an input bit propagates per standard Verilog `&` semantics. No masking.

## Timing
- `y` and `y_all` have zero-cycle latency, gate delay only. They must settle within the same simulation timestep as the input change.
- `y_q`, `rise`, `fall`, `hi_count`, and `y_all_d` update on the rising edge of `clk`, with 1-cycle latency from the inputs.
- Reset values, asynchronous on `rst` high and held while `rst` = 1:
  - `y_q = 0`
  - `y_all_d = 0`
  - `rise = 0`
  - `fall = 0`
  - `hi_count = 0`
- Reset has no effect on `y` or `y_all`.
- First edge after reset release:
  - `rise` fires if `y_all` = 1, because `y_all_d` resets to 0.
  - `fall` cannot fire on this edge.
- `rise` and `fall` are mutually exclusive and last exactly one cycle per transition.
  - If `y_all` toggles and returns between two clock edges, no pulse is generated.
- Reset asserted mid-count clears `hi_count` immediately, without waiting for a clock edge.
- With `clk` stopped or undefined, the combinational outputs remain fully functional.

## Test plan
- Combinational truth table, WIDTH=1, no clock toggling. Apply each vector and hold 10 ns:
  - `a,b` = 0,0 → `y` = 0
  - `a,b` = 0,1 → `y` = 0
  - `a,b` = 1,0 → `y` = 0
  - `a,b` = 1,1 → `y` = 1 (`y_all` tracks `y` at every step)
- Bitwise vector, WIDTH=4:
  - `a=4'b1100`, `b=4'b1010` → `y=4'b1000`, `y_all=0`
  - `a=b=4'hF` → `y=4'hF`, `y_all=1`
- Registered path, 10 ns clock. Assert `rst`, then release with `a=b=1`:
  - `y_q=0` before the first edge; `y_q=1` after the first edge.
  - `rise=1` for exactly one cycle.
  - Drop `b` to 0 → `fall=1` for one cycle; `y_q=0` one cycle later.
- Saturation, CNT_W=3. Hold `a=b=1` for 10 cycles → `hi_count` reads 1,2,…,7 and then stays at 7.
- Asynchronous reset mid-operation. With `hi_count=5`, assert `rst` between clock edges:
  - `hi_count`, `y_q`, `rise`, and `fall` go to 0 immediately.
  - `y` still equals `a & b`.
- Glitch filtering. Pulse `a` 1→0→1 within one clock period while `b=1` → no `rise` or `fall` pulse is produced.
